dac_setpoint_sink: RTL and testbench
====================================

# dac_setpoint_sink

Consumer end of the DAC address/write stream. Captures `Data16b` at each `wr_one` strobe into a per-ID ping-pong setpoint buffer. On `trig`, it swaps banks and serializes every valid entry of the just-completed bank to the DAC over a 24-bit SPI frame, then pulses `ldac_n`. Sits between the DAC address generator and the DAC pins, one instance per DAC interface.

## Interface
Parameters:
- `MAX_ID_NUM`, 60: number of setpoint IDs; IDs at or above this are ignored.
- `SCLK_DIV`, 4: `clk` cycles per SCLK half-period; must be 2..255.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: capture qualifier; SPI engine runs regardless.
- `trig` in 1: frame boundary; requests bank swap and readout.
- `aie_addr` in 7: ID of current write.
- `Data16b` in 16: setpoint data.
- `wr_one` in 1: single-cycle capture strobe.
- `mask` in 1: per-ID enable for current write.
- `busy` out 1: readout in progress.
- `done` out 1: one-cycle pulse after LDAC completes.
- `overrun` out 1: sticky; `trig` arrived while busy; cleared by reset only.
- `dac_csn` out 1: SPI chip select, active low.
- `dac_sclk` out 1: SPI clock, idle low.
- `dac_sdi` out 1: SPI data, MSB first.
- `ldac_n` out 1: DAC load strobe, active low.

## Operation
- Buffer: 2 banks × `MAX_ID_NUM` × 16 bits, plus a valid bit per entry. `wbank` selects the capture bank; readout uses `~wbank`.
- Capture: when `clk_enable & wr_one & (aie_addr < MAX_ID_NUM)`:
  - `buf[wbank][aie_addr] <= Data16b`
  - `valid[wbank][aie_addr] <= 1` (subject to Configuration)
  - Repeated writes to one ID within a frame: last write wins.
- `trig` in IDLE: toggle `wbank`, clear all valid bits of the new capture bank, and enter SCAN with id=0, all in the same cycle.
- `trig` while busy: set `overrun`. No swap. Capture continues into the current bank. Readout is unaffected.
- `trig` and capture in the same cycle: capture goes to the old `wbank`. That bank becomes the readout bank, so the data is included in this readout.
- States:
  - IDLE
  - SCAN: if `valid[rbank][id]`, go to CS_SETUP; else id+1. When id reaches `MAX_ID_NUM`, go to LDAC. One ID per cycle.
  - CS_SETUP: `SCLK_DIV` cycles.
  - SHIFT: 24 bits.
  - CS_HOLD: `SCLK_DIV` cycles, then SCAN with id+1.
  - LDAC: `ldac_n` low for 2 cycles.
  - DONE: 1 cycle, `done`=1.
  - Then back to IDLE.
- SPI frame, 24 bits: {8'h00 | id[6:0] zero-extended to 8 bits, data[15:0]}, MSB first.
- No valid entries: SCAN walks all IDs with no CS activity, then runs LDAC and DONE as normal.
- Reset mid-readout: return to IDLE immediately and drive outputs to idle levels. The frame is truncated, and `dac_csn` deasserts the next cycle.

## Timing
- Reset values:
  - `busy`, `done`, `overrun`, `dac_sclk`, `dac_sdi` = 0
  - `dac_csn`, `ldac_n` = 1
  - `wbank` = 0
  - all valid bits = 0
- All outputs are registered.
- `busy` rises the cycle after `trig` and falls the cycle `done` rises.
- `dac_csn` falls on entry to CS_SETUP.
- `dac_sdi` changes with SCLK falling, or at CS_SETUP entry for bit 23. The DAC samples on SCLK rising.
- SCLK period = 2·`SCLK_DIV` cycles.
- Per-entry cost = 50·`SCLK_DIV` cycles of CS activity, plus 1 SCAN cycle.
- `trig` to first `dac_csn` fall with ID 0 valid: 2 cycles.
- Full readout with N valid IDs = 1 + `MAX_ID_NUM` + N·50·`SCLK_DIV` + 2 + 1 cycles.

## Configuration
- `DAC_SINK_MASK_EN` defined: the capture valid bit is written with `mask`. A write with `mask`=0 stores data but leaves the entry invalid, so it is not transmitted.
- `DAC_SINK_MASK_EN` undefined: `mask` is ignored and every qualified capture sets valid.

## Structure
- Shared package `dac_pkg`:
  - `MAX_ID_NUM` default
  - SPI frame width (24)
  - LDAC width (2)
  - readout state enum
- Sub-module `dac_spi_shifter`:
  - contains the SCLK divider, 24-bit shift register and `dac_csn` sequencing (CS_SETUP, SHIFT, CS_HOLD)
  - `start`/`ready` handshake with the parent FSM
  - the parent owns the buffers, SCAN, LDAC and DONE.

## Test plan
- Basic readout: capture ID 0=16'h1234 and ID 5=16'hABCD (mask=1), then `trig`. Expect exactly two frames: 24'h001234 and 24'h05ABCD. Then `ldac_n` low for 2 cycles, `done` pulse, and a total readout time matching the formula.
- Masked and out-of-range writes: mask=0 on ID 3, and a write to ID 60. With `DAC_SINK_MASK_EN`, neither is transmitted. Without the macro, ID 3 is transmitted and ID 60 still is not.
- Overrun and ping-pong: `trig` during SHIFT sets `overrun`=1, readout completes unchanged, and the next `trig` transmits only the data captured since the previous swap.
- Simultaneous events: write ID 7=16'h0007 in the same cycle as `trig`. The value appears in this readout. Also write ID 7 twice in one frame; only the last value is sent.
- Reset mid-frame: assert `reset` at bit 10 of SHIFT. The next cycle shows `dac_csn`=1, `busy`=0, `overrun`=0, valid bits cleared, and no `done`.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants, state encodings and frame packing for the DAC setpoint sink.
package dac_pkg;
  localparam int MAX_ID_NUM_DEF = 60;
  localparam int FRAME_W        = 24;
  localparam int LDAC_W         = 2;

  typedef enum logic [2:0] {RD_IDLE, RD_SCAN, RD_XFER, RD_LDAC, RD_DONE} rd_state_t;
  typedef enum logic [1:0] {SP_IDLE, SP_SETUP, SP_SHIFT, SP_HOLD} sp_state_t;

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [6:0] id, input logic [15:0] data);
    return {1'b0, id, data};
  endfunction
endpackage

// File: rtl/dac_setpoint_sink_if.sv
// Write-side stream from the DAC address generator into the setpoint sink.
interface dac_setpoint_sink_if;
  logic        clk_enable;
  logic        trig;
  logic [6:0]  aie_addr;
  logic [15:0] Data16b;
  logic        wr_one;
  logic        mask;

  modport master (output clk_enable, trig, aie_addr, Data16b, wr_one, mask);
  modport slave  (input  clk_enable, trig, aie_addr, Data16b, wr_one, mask);
endinterface

// File: rtl/dac_spi_shifter.sv
// One 24-bit SPI frame per start: CS setup, 24 SCLK periods MSB first, CS hold.
module dac_spi_shifter
  import dac_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               ready,
  output logic               csn,
  output logic               sclk,
  output logic               sdi
);
  sp_state_t          st, st_nxt;
  logic [7:0]         cnt;
  logic [4:0]         bitc;
  logic [FRAME_W-1:0] sr;
  logic               cnt_end;

  assign cnt_end = (cnt == 8'(SCLK_DIV - 1));
  // ready covers the last hold cycle so the parent can rescan with no gap
  assign ready   = (st == SP_IDLE) | ((st == SP_HOLD) & cnt_end);

  always_comb begin
    st_nxt = st;
    case (st)
      SP_IDLE:  if (start) st_nxt = SP_SETUP;
      SP_SETUP: if (cnt_end) st_nxt = SP_SHIFT;
      SP_SHIFT: if (cnt_end & sclk & (bitc == 5'(FRAME_W - 1))) st_nxt = SP_HOLD;
      SP_HOLD:  if (cnt_end) st_nxt = SP_IDLE;
      default:  st_nxt = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= SP_IDLE;
      cnt  <= '0;
      bitc <= '0;
      sr   <= '0;
      csn  <= 1'b1;
      sclk <= 1'b0;
      sdi  <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= ((st == SP_IDLE) | cnt_end) ? 8'd0 : cnt + 8'd1;
      case (st)
        SP_IDLE: if (start) begin
          sr   <= frame;
          sdi  <= frame[FRAME_W-1];
          csn  <= 1'b0;
          bitc <= '0;
        end
        SP_SHIFT: if (cnt_end) begin
          sclk <= ~sclk;
          // falling edge: present the next bit; zeros shift in after bit 0
          if (sclk) begin
            bitc <= bitc + 5'd1;
            sr   <= {sr[FRAME_W-2:0], 1'b0};
            sdi  <= sr[FRAME_W-2];
          end
        end
        SP_HOLD: if (cnt_end) csn <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dac_setpoint_sink.sv
// Ping-pong setpoint buffer with trig-driven SPI readout and LDAC pulse.
// Build option: DAC_SINK_MASK_EN makes the capture valid bit follow mask.
module dac_setpoint_sink
  import dac_pkg::*;
#(
  parameter int MAX_ID_NUM = MAX_ID_NUM_DEF,
  parameter int SCLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset,
  dac_setpoint_sink_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                dac_csn,
  output logic                dac_sclk,
  output logic                dac_sdi,
  output logic                ldac_n
);
  localparam int         IDW     = $clog2(MAX_ID_NUM);
  localparam logic [6:0] LAST_ID = 7'(MAX_ID_NUM - 1);

  rd_state_t             st, st_nxt;
  logic [6:0]            id, id_nxt;
  logic                  wbank;
  logic [1:0]            lcnt;
  logic                  start, sh_ready, cap, vld_wr;
  logic [15:0]           mem [2][MAX_ID_NUM];
  logic [MAX_ID_NUM-1:0] vld [2];
  logic [IDW-1:0]        wa, ra;
  logic [FRAME_W-1:0]    frame;

  assign wa  = bus.aie_addr[IDW-1:0];
  assign ra  = id[IDW-1:0];
  assign cap = bus.clk_enable & bus.wr_one & (32'(bus.aie_addr) < MAX_ID_NUM);

`ifdef DAC_SINK_MASK_EN
  assign vld_wr = bus.mask;
`else
  logic unused_mask;
  assign unused_mask = bus.mask;
  assign vld_wr      = 1'b1;
`endif

  always_ff @(posedge clk) if (cap) mem[wbank][wa] <= bus.Data16b;

  always_comb begin
    st_nxt = st;
    id_nxt = id;
    start  = 1'b0;
    case (st)
      RD_IDLE: if (bus.trig) begin
        st_nxt = RD_SCAN;
        id_nxt = '0;
      end
      RD_SCAN: begin
        if (vld[~wbank][ra]) begin
          start  = 1'b1;
          st_nxt = RD_XFER;
        end else if (id == LAST_ID) st_nxt = RD_LDAC;
        else id_nxt = id + 7'd1;
      end
      RD_XFER: if (sh_ready) begin
        if (id == LAST_ID) st_nxt = RD_LDAC;
        else begin
          st_nxt = RD_SCAN;
          id_nxt = id + 7'd1;
        end
      end
      RD_LDAC: if (lcnt == 2'(LDAC_W - 1)) st_nxt = RD_DONE;
      RD_DONE: st_nxt = RD_IDLE;
      default: st_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= RD_IDLE;
      id      <= '0;
      wbank   <= 1'b0;
      lcnt    <= '0;
      overrun <= 1'b0;
      vld[0]  <= '0;
      vld[1]  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ldac_n  <= 1'b1;
    end else begin
      st   <= st_nxt;
      id   <= id_nxt;
      lcnt <= (st == RD_LDAC) ? lcnt + 2'd1 : 2'd0;
      if (cap) vld[wbank][wa] <= vld_wr;
      // a trig anywhere outside IDLE (DONE included) is a missed frame
      if (bus.trig) begin
        if (st == RD_IDLE) begin
          wbank       <= ~wbank;
          vld[~wbank] <= '0;
        end else overrun <= 1'b1;
      end
      busy   <= (st_nxt == RD_SCAN) | (st_nxt == RD_XFER) | (st_nxt == RD_LDAC);
      done   <= (st_nxt == RD_DONE);
      ldac_n <= (st_nxt != RD_LDAC);
    end
  end

  assign frame = mk_frame(id, mem[~wbank][ra]);

  dac_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .frame (frame),
    .ready (sh_ready),
    .csn   (dac_csn),
    .sclk  (dac_sclk),
    .sdi   (dac_sdi)
  );
endmodule

// File: tb/tb_dac_setpoint_sink.sv
// Directed bench: stimulus pushes expected SPI frames, a monitor decodes the pins and compares.
module tb_dac_setpoint_sink;
  logic clk, reset;
  logic busy, done, overrun, dac_csn, dac_sclk, dac_sdi, ldac_n;

  dac_setpoint_sink_if bus ();

  dac_setpoint_sink #(.MAX_ID_NUM(60), .SCLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .done(done), .overrun(overrun),
    .dac_csn(dac_csn), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .ldac_n(ldac_n)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, errors = 0;
  int cyc = 0, t_trig = 0, t_fall = -1, t_done = -1, nb = 0, lo_cnt = 0;
  logic [23:0] sh = '0;
  logic [23:0] exp_q [$];
  logic p_sclk = 1'b0, p_csn = 1'b1, p_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // monitor: decode frames on SCLK rising, compare on CS release
  initial forever begin
    @(negedge clk);
    if (reset) begin
      nb = 0;
      lo_cnt = 0;
    end else begin
      if (!dac_csn && p_csn) begin nb = 0; if (t_fall < 0) t_fall = cyc; end
      if (!dac_csn && dac_sclk && !p_sclk) begin sh = {sh[22:0], dac_sdi}; nb++; end
      if (dac_csn && !p_csn) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame actual=%h required=none", sh);
        end else begin
          check("frame_bits", nb, 24);
          check("frame_data", sh, exp_q.pop_front());
        end
      end
      if (!ldac_n) lo_cnt++;
      if (done && !p_done) begin
        check("ldac_low_cycles", lo_cnt, 2);
        check("busy_at_done", busy, 0);
        lo_cnt = 0;
        t_done = cyc;
      end
    end
    p_sclk = dac_sclk; p_csn = dac_csn; p_done = done;
  end

  task automatic step(input logic tg, input logic wr, input logic [6:0] a,
                      input logic [15:0] d, input logic m, input bit rec);
    @(negedge clk);
    bus.trig = tg; bus.wr_one = wr; bus.aie_addr = a; bus.Data16b = d; bus.mask = m;
    if (rec) begin t_trig = cyc; t_fall = -1; end
    @(negedge clk);
    bus.trig = 1'b0; bus.wr_one = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d, input logic m);
    step(1'b0, 1'b1, a, d, m, 1'b0);
  endtask

  task automatic trig_rd();
    step(1'b1, 1'b0, 7'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic wait_done(input string nm, input int exp_cyc);
    int n = 0;
    t_done = -1;
    while (t_done < 0 && n < 3000) begin @(negedge clk); n++; end
    if (t_done < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end else check(nm, t_done - t_trig + 1, exp_cyc);
    check({nm, "_frames_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_bits(input int k);
    int n = 0;
    while ((dac_csn || nb < k) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL wait_bits_timeout actual=%0d required=%0d", nb, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.clk_enable = 1'b1; bus.trig = 1'b0; bus.wr_one = 1'b0;
    bus.aie_addr = '0; bus.Data16b = '0; bus.mask = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {busy, done, overrun, dac_csn, dac_sclk, dac_sdi, ldac_n}, 7'b0001001);

    // basic readout: IDs 0 and 5
    wr(7'd0, 16'h1234, 1'b1);
    wr(7'd5, 16'hABCD, 1'b1);
    exp_q.push_back(24'h001234);
    exp_q.push_back(24'h05ABCD);
    trig_rd();
    check("busy_after_trig", busy, 1);
    wait_done("basic_cycles", 464);
    check("csn_latency", t_fall - t_trig, 2);

    // masked, out-of-range, and clock-disabled writes
    wr(7'd3, 16'h3333, 1'b0);
    wr(7'd60, 16'h6060, 1'b1);
    wr(7'd1, 16'h0101, 1'b1);
    bus.clk_enable = 1'b0;
    wr(7'd8, 16'h8888, 1'b1);
    bus.clk_enable = 1'b1;
    exp_q.push_back(24'h010101);
`ifdef DAC_SINK_MASK_EN
    trig_rd();
    wait_done("mask_cycles", 264);
`else
    exp_q.push_back(24'h033333);
    trig_rd();
    wait_done("mask_cycles", 464);
`endif
    check("overrun_clear", overrun, 0);

    // overrun during SHIFT, then ping-pong isolation
    wr(7'd2, 16'h2222, 1'b1);
    exp_q.push_back(24'h022222);
    trig_rd();
    wait_bits(5);
    wr(7'd9, 16'h9999, 1'b1);
    step(1'b1, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0);
    check("overrun_set", overrun, 1);
    wait_done("overrun_cycles", 264);
    check("overrun_sticky", overrun, 1);
    exp_q.push_back(24'h099999);
    trig_rd();
    wait_done("pingpong_cycles", 264);

    // last write wins, and a write coincident with trig lands in this readout
    wr(7'd7, 16'h1111, 1'b1);
    exp_q.push_back(24'h070007);
    step(1'b1, 1'b1, 7'd7, 16'h0007, 1'b1, 1'b1);
    wait_done("simul_cycles", 264);

    // reset mid-frame
    wr(7'd4, 16'h4444, 1'b1);
    trig_rd();
    t_done = -1;
    wait_bits(10);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_frame", {dac_csn, busy, overrun, done, dac_sclk, ldac_n}, 6'b100001);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", t_done, -1);
    trig_rd();
    wait_done("empty_cycles", 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
